// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, branch and multi-cycle EX stall/flush control with saturating perf counters
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdE,
  input  logic             loadE,
  input  logic             pcsrcE,
  input  logic             mc_startE,
  input  logic             clr_cnt,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             mc_busy,
  output logic             mc_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MC_BUSY} state_t;
  localparam logic [3:0] LD = 4'(MC_LAT > 1 ? MC_LAT - 2 : 0);
  state_t state, state_n;
  logic [3:0] mc_cnt, mc_cnt_n;
  logic run, mc_go, mc_one, hold, lw, br;
  always_comb begin
    run = state == RUN;
    mc_go = run & mc_startE & (MC_LAT > 1);
    mc_one = run & mc_startE & (MC_LAT == 1);
    hold = mc_go | (!run & mc_cnt != 4'd0);
    lw = run & !mc_startE & loadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));
    br = run & !mc_startE & pcsrcE;
    state_n = mc_go ? MC_BUSY : (!run && mc_cnt == 4'd0) ? RUN : state;
    mc_cnt_n = mc_go ? LD : (!run && mc_cnt != 4'd0) ? mc_cnt - 4'd1 : mc_cnt;
    stallF = !reset & (hold | lw);
    stallD = !reset & (hold | lw);
    stallE = !reset & hold;
    flushM = !reset & hold;
    flushD = !reset & br;
    flushE = !reset & (lw | br);
    mc_busy = !reset & !run;
    mc_done = !reset & (mc_one | (!run & mc_cnt == 4'd0));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      mc_cnt <= 4'd0;
    end else begin
      state <= state_n;
      mc_cnt <= mc_cnt_n;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stallF && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flushD && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three parameterisations driven in lockstep and checked against a residency-position model
module tb_hazard_ctrl;
  logic clk = 0, reset = 1;
  logic [4:0] rs1D = 0, rs2D = 0, rdE = 0;
  logic loadE = 0, pcsrcE = 0, mc_startE = 0, clr_cnt = 0;
  logic [7:0] ctl [3];
  logic [31:0] sc [3], fc [3];
  int n_cmp = 0, n_bad = 0;
  int lat [3] = '{4, 1, 8};
  longint mx [3] = '{64'hFFFF_FFFF, 15, 15};
  int pos [3] = '{-1, -1, -1}, npos [3] = '{-1, -1, -1};
  longint scnt [3] = '{0, 0, 0}, fcnt [3] = '{0, 0, 0};
  longint nscnt [3] = '{0, 0, 0}, nfcnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int LAT = g == 0 ? 4 : g == 1 ? 1 : 8;
    localparam int CW = g == 0 ? 32 : 4;
    logic [CW-1:0] s, f;
    hazard_ctrl #(.MC_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
      .loadE(loadE), .pcsrcE(pcsrcE), .mc_startE(mc_startE), .clr_cnt(clr_cnt),
      .stallF(ctl[g][7]), .stallD(ctl[g][6]), .stallE(ctl[g][5]), .flushD(ctl[g][4]),
      .flushE(ctl[g][3]), .flushM(ctl[g][2]), .mc_busy(ctl[g][1]), .mc_done(ctl[g][0]),
      .stall_cnt(s), .flush_cnt(f));
    assign sc[g] = 32'(s);
    assign fc[g] = 32'(f);
  end

  task automatic chk(input string nm, input int i, input longint a, input longint e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s u%0d t=%0t got %0h want %0h", nm, i, $time, a, e);
    end
  endtask

  // position p counts EX cycles already spent by the current op (0 = first cycle)
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      int p;
      bit inop, st, lw, br;
      inop = pos[i] >= 0 || mc_startE;
      p = pos[i] >= 0 ? pos[i] : 0;
      st = p < lat[i] - 1;
      lw = loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      br = pcsrcE;
      if (reset) e = 8'h00;
      else if (inop) e = {st, st, st, 1'b0, 1'b0, st, p >= 1, p == lat[i] - 1};
      else e = {lw, lw, 1'b0, br, lw | br, 3'b000};
      chk("ctl", i, ctl[i], e);
      chk("stall_cnt", i, sc[i], scnt[i]);
      chk("flush_cnt", i, fc[i], fcnt[i]);
      npos[i] = (reset || !inop || !st) ? -1 : p + 1;
      nscnt[i] = clr_cnt ? 0 : (e[7] && scnt[i] < mx[i]) ? scnt[i] + 1 : scnt[i];
      nfcnt[i] = clr_cnt ? 0 : (e[4] && fcnt[i] < mx[i]) ? fcnt[i] + 1 : fcnt[i];
    end
  end

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        pos[i] <= -1;
        scnt[i] <= 0;
        fcnt[i] <= 0;
      end else begin
        pos[i] <= npos[i];
        scnt[i] <= nscnt[i];
        fcnt[i] <= nfcnt[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    loadE = 0; pcsrcE = 0; mc_startE = 0; clr_cnt = 0;
    rdE = 0; rs1D = 0; rs2D = 0;
  endtask

  initial begin
    repeat (2) cyc();
    #2 chk("rst_ctl", 0, ctl[0], 0);
    chk("rst_cnt", 0, sc[0], 0);
    cyc(); reset = 0;
    cyc(); loadE = 1; rdE = 5; rs1D = 5;
    #2 chk("lw", 0, ctl[0], 8'b1100_1000);
    cyc(); idle();
    #2 chk("lw_cnt", 0, sc[0], 1);
    cyc(); loadE = 1;
    #2 chk("rd0", 0, ctl[0], 0);
    cyc(); idle(); pcsrcE = 1;
    #2 chk("br", 0, ctl[0], 8'b0001_1000);
    cyc(); loadE = 1; rdE = 7; rs2D = 7;
    #2 chk("lw_br", 0, ctl[0], 8'b1101_1000);
    cyc(); idle();
    #2 chk("lw_br_s", 0, sc[0], 2);
    chk("lw_br_f", 0, fc[0], 2);
    for (int k = 0; k < 8; k++) begin
      cyc(); mc_startE = 1;
      #2 chk("mc4", 0, ctl[0], (k % 4) < 3 ? {6'b111001, k % 4 != 0, 1'b0} : 8'b0000_0011);
      chk("mc1", 1, ctl[1], 8'b0000_0001);
    end
    cyc(); idle();
    #2 chk("mc_cnt", 0, sc[0], 8);
    chk("mc1_cnt", 1, sc[1], 2);
    cyc(); mc_startE = 1;
    cyc(); idle();
    cyc();
    #1 chk("mc8_mid", 2, ctl[2], 8'b1110_0110);
    #1 reset = 1;
    #1 chk("rst_async", 2, ctl[2], 0);
    chk("rst_async", 0, ctl[0], 0);
    cyc(); cyc(); reset = 0;
    cyc();
    #2 chk("post_rst", 2, ctl[2], 0);
    chk("post_rst_s", 2, sc[2], 0);
    chk("post_rst_f", 0, fc[0], 0);
    cyc(); loadE = 1; rdE = 3; rs1D = 3;
    repeat (20) cyc();
    #2 chk("sat", 1, sc[1], 15);
    chk("sat", 2, sc[2], 15);
    chk("nosat", 0, sc[0], 20);
    clr_cnt = 1;
    cyc(); idle();
    #2 chk("clr", 1, sc[1], 0);
    chk("clr", 0, sc[0], 0);
    repeat (400) begin
      cyc();
      reset = $urandom_range(0, 49) == 0;
      mc_startE = $urandom_range(0, 7) == 0;
      clr_cnt = $urandom_range(0, 29) == 0;
      loadE = $urandom_range(0, 1) == 1;
      pcsrcE = $urandom_range(0, 3) == 0;
      rdE = 5'($urandom_range(0, 3));
      rs1D = 5'($urandom_range(0, 3));
      rs2D = 5'($urandom_range(0, 3));
    end
    cyc(); idle(); reset = 0;
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
